mod_sq_loop_ctrl: RTL and testbench

MOD_SQ_LOOP_CTRL -- requirements
Module: mod_sq_loop_ctrl

---
 rtl/mod_sq_loop_ctrl_if.sv | 22 ++
 rtl/mod_sq_loop_ctrl.sv | 139 +++++++++++++
 tb/tb_mod_sq_loop_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_sq_loop_ctrl_if.sv
// rtl/mod_sq_loop_ctrl_if.sv - multiplier request/response bus between the squaring loop and its multiplier
interface mod_sq_loop_ctrl_if #(
    parameter int BITS = 382
);
    logic            req_val;
    logic            req_rdy;
    logic [BITS-1:0] req_dat_a;
    logic [BITS-1:0] req_dat_b;
    logic            rsp_val;
    logic            rsp_rdy;
    logic [BITS-1:0] rsp_dat;

    modport master (
        output req_val, req_dat_a, req_dat_b, rsp_rdy,
        input  req_rdy, rsp_val, rsp_dat
    );

    modport slave (
        input  req_val, req_dat_a, req_dat_b, rsp_rdy,
        output req_rdy, rsp_val, rsp_dat
    );
endinterface

// File: rtl/mod_sq_loop_ctrl.sv
// rtl/mod_sq_loop_ctrl.sv - repeated-squaring loop controller driving an external multiplier
// Optional WAIT watchdog enabled by macro MOD_SQ_LOOP_WDOG_EN.
module mod_sq_loop_ctrl #(
    parameter int BITS     = 382,
    parameter int ITER_W   = 64,
    parameter int WDOG_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_val,
    output logic              o_rdy,
    input  logic [BITS-1:0]   i_dat,
    input  logic [ITER_W-1:0] i_iter,
    output logic              o_val,
    input  logic              i_rdy,
    output logic [BITS-1:0]   o_dat,
    output logic [ITER_W-1:0] o_cnt,
    output logic              o_err,
    output logic              o_mul_val,
    input  logic              i_mul_rdy,
    output logic [BITS-1:0]   o_mul_dat_a,
    output logic [BITS-1:0]   o_mul_dat_b,
    input  logic              i_mul_val,
    output logic              o_mul_rdy,
    input  logic [BITS-1:0]   i_mul_dat
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_nxt;
    logic [BITS-1:0]   r_x, w_x_nxt;
    logic [ITER_W-1:0] r_rem, w_rem_nxt;
    logic [ITER_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_rdy, r_val, r_mul_val, r_mul_rdy;
    logic [BITS-1:0]   r_dat, r_mul_a, r_mul_b;
    logic              w_acc, w_req, w_rsp, w_out, w_wd_fire;

    assign w_acc = r_rdy && i_val;
    assign w_req = r_mul_val && i_mul_rdy;
    assign w_rsp = r_mul_rdy && i_mul_val;
    assign w_out = r_val && i_rdy;

`ifdef MOD_SQ_LOOP_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
    logic [WD_W-1:0] r_wd;
    logic            r_err;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                 r_wd <= '0;
        else if (r_state != S_WAIT) r_wd <= '0;
        else                        r_wd <= r_wd + 1'b1;
    end

    assign w_wd_fire = (r_state == S_WAIT) && !i_mul_val && (r_wd == WD_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)         r_err <= 1'b0;
        else if (w_acc)     r_err <= 1'b0;
        else if (w_wd_fire) r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign w_wd_fire = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_nxt = (i_iter == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_req) w_nxt = S_WAIT;
            S_WAIT: begin
                if (w_rsp)          w_nxt = (r_rem == ITER_W'(1)) ? S_DONE : S_ISSUE;
                else if (w_wd_fire) w_nxt = S_DONE;
            end
            S_DONE:  if (w_out) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_x_nxt   = r_x;
        w_rem_nxt = r_rem;
        w_cnt_nxt = r_cnt;
        if (r_state == S_IDLE && w_acc) begin
            w_x_nxt   = i_dat;
            w_rem_nxt = i_iter;
            w_cnt_nxt = '0;
        end else if (r_state == S_WAIT && w_rsp) begin
            w_x_nxt   = i_mul_dat;
            w_rem_nxt = r_rem - 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Handshake flags are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x       <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_rdy     <= 1'b0;
            r_val     <= 1'b0;
            r_mul_val <= 1'b0;
            r_mul_rdy <= 1'b0;
            r_dat     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
        end else begin
            r_x       <= w_x_nxt;
            r_rem     <= w_rem_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rdy     <= (w_nxt == S_IDLE);
            r_val     <= (w_nxt == S_DONE);
            r_mul_val <= (w_nxt == S_ISSUE);
            r_mul_rdy <= (w_nxt == S_WAIT);
            if (w_nxt == S_ISSUE && r_state != S_ISSUE) begin
                r_mul_a <= w_x_nxt;
                r_mul_b <= w_x_nxt;
            end
            if (w_nxt == S_DONE && r_state != S_DONE) r_dat <= w_x_nxt;
        end
    end

    assign o_rdy       = r_rdy;
    assign o_val       = r_val;
    assign o_dat       = r_dat;
    assign o_cnt       = r_cnt;
    assign o_mul_val   = r_mul_val;
    assign o_mul_rdy   = r_mul_rdy;
    assign o_mul_dat_a = r_mul_a;
    assign o_mul_dat_b = r_mul_b;
endmodule

// File: tb/tb_mod_sq_loop_ctrl.sv
// tb/tb_mod_sq_loop_ctrl.sv - self-checking bench for mod_sq_loop_ctrl with a mod-13 latency-4 multiplier model
module tb_mod_sq_loop_ctrl;
    localparam int BITS   = 16;
    localparam int ITER_W = 8;
    localparam int WDOG   = 16;
    localparam int LAT    = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_val = 1'b0;
    logic              i_rdy = 1'b1;
    logic [BITS-1:0]   i_dat = '0;
    logic [ITER_W-1:0] i_iter = '0;
    logic              o_rdy, o_val, o_err;
    logic [BITS-1:0]   o_dat;
    logic [ITER_W-1:0] o_cnt;

    mod_sq_loop_ctrl_if #(.BITS(BITS)) mbus ();

    always #5 i_clk = ~i_clk;

    mod_sq_loop_ctrl #(.BITS(BITS), .ITER_W(ITER_W), .WDOG_CYC(WDOG)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_val       (i_val),
        .o_rdy       (o_rdy),
        .i_dat       (i_dat),
        .i_iter      (i_iter),
        .o_val       (o_val),
        .i_rdy       (i_rdy),
        .o_dat       (o_dat),
        .o_cnt       (o_cnt),
        .o_err       (o_err),
        .o_mul_val   (mbus.req_val),
        .i_mul_rdy   (mbus.req_rdy),
        .o_mul_dat_a (mbus.req_dat_a),
        .o_mul_dat_b (mbus.req_dat_b),
        .i_mul_val   (mbus.rsp_val),
        .o_mul_rdy   (mbus.rsp_rdy),
        .i_mul_dat   (mbus.rsp_dat)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        longint dat;
        longint cnt;
        longint err;
        int     lat;
    } exp_t;
    exp_t sb[$];

    // Multiplier model: sees the request handshake at the negedge before it, answers LAT edges later.
    int              pend = -1;
    logic [BITS-1:0] pend_dat;
    int              hs_cnt = 0;
    int              viol = 0;
    bit              mute = 1'b0;

    initial begin
        mbus.req_rdy = 1'b1;
        mbus.rsp_val = 1'b0;
        mbus.rsp_dat = '0;
    end

    always @(negedge i_clk) begin
        if (mbus.req_val && mbus.rsp_rdy) viol++;
        if (mbus.rsp_val) mbus.rsp_val = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mbus.rsp_val = 1'b1;
                mbus.rsp_dat = pend_dat;
                pend = -1;
            end
        end
        if (i_rst && mbus.req_val && mbus.req_rdy) begin
            hs_cnt++;
            if (!mute) begin
                pend     = LAT;
                pend_dat = BITS'(((int'(mbus.req_dat_a) % 13) * (int'(mbus.req_dat_b) % 13)) % 13);
            end
        end
    end

    function automatic longint sq_ref(input longint x0, input int n);
        longint x = x0;
        for (int k = 0; k < n; k++) x = (x * x) % 13;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_job(input longint x0, input int n, input longint edat,
                             input longint ecnt, input longint eerr, input int elat);
        exp_t e;
        bit   ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge i_clk);
            if (o_rdy) ok = 1'b1;
        end
        if (!ok) chk("o_rdy_timeout", 64'(o_rdy), 64'd1);
        @(posedge i_clk);
        #1;
        i_val  = 1'b1;
        i_dat  = BITS'(x0);
        i_iter = ITER_W'(n);
        e.dat = edat; e.cnt = ecnt; e.err = eerr; e.lat = elat;
        sb.push_back(e);
        step();
        i_val = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   lat = 0;
        bit   seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge i_clk);
            lat++;
            if (o_val) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(o_val), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_dat"}, 64'(o_dat), e.dat);
        chk({tag, "_cnt"}, 64'(o_cnt), e.cnt);
        chk({tag, "_err"}, 64'(o_err), e.err);
        if (e.lat >= 0) chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
    endtask

    task automatic take_result(input string tag);
        i_rdy = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_val_drop"}, 64'(o_val), 64'd0);
        chk({tag, "_rdy_back"}, 64'(o_rdy), 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"}, 64'(o_rdy), 64'd0);
        chk({tag, "_val"}, 64'(o_val), 64'd0);
        chk({tag, "_dat"}, 64'(o_dat), 64'd0);
        chk({tag, "_cnt"}, 64'(o_cnt), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'd0);
        chk({tag, "_mval"}, 64'(mbus.req_val), 64'd0);
        chk({tag, "_mrdy"}, 64'(mbus.rsp_rdy), 64'd0);
        chk({tag, "_ma"}, 64'(mbus.req_dat_a), 64'd0);
        chk({tag, "_mb"}, 64'(mbus.req_dat_b), 64'd0);
    endtask

    initial begin
        int hs0;
        int vcount;
        bit ok;

        repeat (3) step();
        @(negedge i_clk);
        chk_reset_outs("reset");
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_rdy_hold", 64'(o_rdy), 64'd0);
        @(negedge i_clk);
        chk("rst_rdy_first_edge", 64'(o_rdy), 64'd1);

        start_job(3, 0, 3, 0, 0, 1);
        wait_result("n0");
        take_result("n0");

        hs0 = hs_cnt;
        start_job(3, 3, sq_ref(3, 3), 3, 0, 1 + 3 * (LAT + 1));
        wait_result("n3");
        chk("n3_handshakes", 64'(hs_cnt - hs0), 64'd3);
        take_result("n3");

        mbus.req_rdy = 1'b0;
        i_rdy = 1'b0;
        start_job(5, 2, sq_ref(5, 2), 2, 0, -1);
        for (int k = 0; k < 7; k++) begin
            @(negedge i_clk);
            chk("stall_mval", 64'(mbus.req_val), 64'd1);
            chk("stall_a", 64'(mbus.req_dat_a), 64'd5);
            chk("stall_b", 64'(mbus.req_dat_b), 64'd5);
            step();
        end
        mbus.req_rdy = 1'b1;
        wait_result("stall");
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge i_clk);
            chk("hold_val", 64'(o_val), 64'd1);
            chk("hold_dat", 64'(o_dat), 64'd1);
            chk("hold_rdy", 64'(o_rdy), 64'd0);
        end
        take_result("stall");

        start_job(2, 255, sq_ref(2, 255), 255, 0, 1 + 255 * (LAT + 1));
        wait_result("nmax");
        take_result("nmax");

        start_job(3, 5, 0, 0, 0, -1);
        void'(sb.pop_back());
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge i_clk);
            if (o_cnt == ITER_W'(1) && mbus.rsp_rdy) ok = 1'b1;
        end
        chk("second_wait_reached", 64'(ok), 64'd1);
        i_rst = 1'b0;
        #1 chk_reset_outs("midrst");
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        repeat (6) begin
            @(negedge i_clk);
            chk("late_rsp_mval", 64'(mbus.req_val), 64'd0);
            chk("late_rsp_cnt", 64'(o_cnt), 64'd0);
        end
        chk("late_rsp_val", 64'(o_val), 64'd0);
        chk("late_rsp_rdy", 64'(o_rdy), 64'd1);

        start_job(2, 1, 4, 1, 0, 1 + (LAT + 1));
        wait_result("after_rst");
        take_result("after_rst");

        chk("one_outstanding", 64'(viol), 64'd0);

        mute = 1'b1;
`ifdef MOD_SQ_LOOP_WDOG_EN
        start_job(7, 2, 7, 0, 1, 2 + WDOG);
        wait_result("wdog");
        take_result("wdog");
`else
        start_job(7, 2, 0, 0, 0, -1);
        void'(sb.pop_back());
        vcount = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge i_clk);
            if (o_val) vcount++;
        end
        chk("no_wdog_val", 64'(vcount), 64'd0);
        chk("no_wdog_err", 64'(o_err), 64'd0);
        chk("no_wdog_still_wait", 64'(mbus.rsp_rdy), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
